eth_rx: RTL and testbench
=========================

Name: eth_rx

Overview:
- 10BASE-T receive path: the counterpart of the existing Manchester transmitter and link-pulse generator.
- Samples the comparator output of the RX pair at `clk` (40 MHz PLL clock, 4 samples per 100 ns bit).
- Decodes Manchester, strips preamble/SFD, and emits frame bytes with strobes.
- Independently tracks normal link pulses (NLP) to report link status to the MAC-side logic.

Parameters:
- SPB, 4, `clk` samples per bit period.
- PRE_MIN, 16, minimum alternating preamble bits before SFD is accepted.
- NLP_MIN, 2, minimum NLP high width in cycles.
- NLP_MAX, 8, maximum NLP high width in cycles.
- LINK_TO, 4000000, cycles without NLP or carrier before `link_ok` drops (100 ms).
- LINK_PULSES, 2, consecutive valid NLPs required to raise `link_ok`.

Ports:
- clk  in  1  40 MHz system clock.
- rst_n  in  1  synchronous active-low reset.
- rx_in  in  1  asynchronous RX comparator output (positive leg).
- rx_data  out  8  received byte, LSB = first bit on wire.
- rx_valid  out  1  one-cycle strobe, `rx_data` valid.
- rx_sof  out  1  high with `rx_valid` for the first byte after SFD.
- rx_eof  out  1  one-cycle pulse at end of frame.
- rx_err  out  1  qualifies `rx_eof`: frame bad.
- carrier  out  1  high while decoder is locked on Manchester activity.
- link_ok  out  1  link integrity status.

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous, active-low, `rst_n`.
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Input conditioning: `rx_in` passes a 2-flop synchronizer, then an edge detector. Decode latency from wire edge to internal bit is 3 cycles.
- Mid-bit tracking: `tcnt` counts cycles since the last accepted mid-bit edge and saturates at 15.
  - An edge with `tcnt` >= SPB-1 (3) is a mid-bit edge: bit = new level (rising = 1, falling = 0); `tcnt` clears.
  - An edge with `tcnt` < SPB-1 is a bit-boundary edge and is ignored.
- Carrier loss: `tcnt` reaching 3*SPB/2 (6) without a mid-bit edge means carrier lost.
- FSM states:
  - IDLE: first mid-bit edge -> PRE; `carrier`=1; `pcnt`=1.
  - PRE: each bit that alternates from the previous one increments `pcnt` (saturates at 63).
    - Two consecutive 1s with `pcnt` >= PRE_MIN -> DATA (SFD found).
    - Two consecutive 1s with `pcnt` < PRE_MIN -> DROP.
    - Two consecutive 0s -> DROP.
  - DATA: shift bits into an LSB-first register. On every 8th bit: `rx_valid`=1 and `rx_data` loaded. `rx_sof` is high on the first such strobe only.
  - DROP: discard bits until carrier loss.
  - Carrier loss from any non-IDLE state -> IDLE and `carrier`=0.
    - Loss from DATA: `rx_eof` pulses.
    - `rx_err`=1 if the bit count mod 8 is not 0 (dribble), or if zero bytes were received.
    - Loss from PRE or DROP: no `rx_eof`.
- Timing relations:
  - `rx_eof` never coincides with `rx_valid`. The last strobe precedes `rx_eof` by at least 1 cycle.
  - `rx_err` is only meaningful while `rx_eof`=1 and is 0 otherwise.
- NLP detector: only active in IDLE.
  - A high pulse of width NLP_MIN..NLP_MAX cycles counts as a valid NLP.
  - Width outside that range resets the consecutive-NLP count to 0.
- Link timer:
  - Reloads to LINK_TO on each valid NLP and on each cycle with `carrier`=1.
  - `link_ok` rises when the consecutive-NLP count reaches LINK_PULSES.
  - `link_ok` falls when the timer expires; the count clears at the same time.
  - A frame received while `link_ok`=0 is still decoded; `link_ok` does not gate data.
- Reset mid-frame: the next cycle is IDLE, no `rx_eof` is emitted, and `link_ok`=0.

Optional Feature:
- Macro: ETH_RX_CRC_EN.
- With the macro defined:
  - A CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF) runs over every byte strobed in DATA, including the FCS.
  - At `rx_eof`, `rx_err` is also set if the register is not the residue 0xDEBB20E3 (before final inversion).
- Without the macro:
  - No CRC logic is built.
  - `rx_err` reflects framing errors only.
- The port list is identical in both builds.

Decomposition:
- Package `eth_pkg`:
  - FSM state enum: IDLE/PRE/DATA/DROP.
  - CRC32_POLY, CRC32_INIT, CRC32_RESIDUE.
  - Default NLP width limits.
- Sub-module `eth_manch_dec`: synchronizer, edge detection, `tcnt`, bit/bit_valid/carrier_lost outputs.
- The framing FSM, NLP/link logic and the optional CRC stay in `eth_rx`.

Test Plan:
- Manchester stream at 100 ns/bit: 56 preamble bits, SFD 0xD5, bytes 0x55 0x01 0xA5, then idle high for 300 ns.
  - Expect 3 `rx_valid` strobes with those values.
  - Expect `rx_sof` on 0x55 and `rx_eof` with `rx_err`=0.
- Same frame truncated 3 bits into the third byte -> two strobes, then `rx_eof` with `rx_err`=1.
- Preamble of only 10 alternating bits before SFD -> no `rx_valid` and no `rx_eof`; `carrier` pulses high then low.
- Three 100 ns high pulses spaced 16 ms:
  - `link_ok` rises after the 2nd pulse.
  - With no further pulses, `link_ok` falls 100 ms after the last one.
  - A 500 ns pulse instead resets the count and `link_ok` stays 0.
- `rst_n` low for 1 cycle mid-byte of a valid frame -> outputs 0 next cycle, no `rx_eof`; the following frame is decoded normally.
- ETH_RX_CRC_EN:
  - 64-byte frame with correct FCS -> `rx_err`=0.
  - Same frame with one payload bit flipped -> `rx_err`=1 at `rx_eof`.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the 10BASE-T receive path (eth_rx).
// The CRC constants and helper are only referenced when ETH_RX_CRC_EN is defined.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        DROP
    } eth_state_t;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int NLP_MIN_DEF = 2;
    localparam int NLP_MAX_DEF = 8;

    // One reflected CRC-32 step; feeding bits LSB-first equals a byte-wise update.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
        crc32_bit = (crc >> 1) ^ ((crc[0] ^ b) ? CRC32_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/eth_manch_dec.sv
// Manchester front end: 2-flop synchronizer, edge detector and mid-bit tracker.
// Emits decoded bits three cycles after the wire edge, plus a carrier-loss pulse.
module eth_manch_dec #(
    parameter int SPB = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rx,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_bit,
    output logic o_bit_vld,
    output logic o_carrier_lost
);

    localparam logic [3:0] TC_MID  = 4'(SPB - 1);
    localparam logic [3:0] TC_LOSS = 4'(3 * SPB / 2 - 1);
    localparam logic [3:0] TC_MAX  = 4'd15;

    logic       r_meta;
    logic       r_sync;
    logic       r_dly;
    logic [3:0] r_tcnt;
    logic       w_edge;
    logic       w_mid;

    assign w_edge  = r_sync ^ r_dly;
    assign w_mid   = w_edge && (r_tcnt >= TC_MID);
    assign o_level = r_sync;
    assign o_rise  = w_edge & r_sync;
    assign o_fall  = w_edge & ~r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta         <= 1'b0;
            r_sync         <= 1'b0;
            r_dly          <= 1'b0;
            r_tcnt         <= 4'd0;
            o_bit          <= 1'b0;
            o_bit_vld      <= 1'b0;
            o_carrier_lost <= 1'b0;
        end else begin
            r_meta         <= i_rx;
            r_sync         <= r_meta;
            r_dly          <= r_sync;
            o_bit_vld      <= w_mid;
            // Pulses once, on the cycle tcnt would step onto 3*SPB/2.
            o_carrier_lost <= !w_mid && (r_tcnt == TC_LOSS);
            if (w_mid) begin
                r_tcnt <= 4'd0;
                o_bit  <= r_sync;
            end else if (r_tcnt != TC_MAX) begin
                r_tcnt <= r_tcnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/eth_rx.sv
// 10BASE-T receiver top: preamble/SFD framing FSM, byte assembly, NLP link monitor.
// Define ETH_RX_CRC_EN to add FCS checking into rx_err at end of frame.
module eth_rx
    import eth_pkg::*;
#(
    parameter int SPB         = 4,
    parameter int PRE_MIN     = 16,
    parameter int NLP_MIN     = NLP_MIN_DEF,
    parameter int NLP_MAX     = NLP_MAX_DEF,
    parameter int LINK_TO     = 4000000,
    parameter int LINK_PULSES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_sof,
    output logic       rx_eof,
    output logic       rx_err,
    output logic       carrier,
    output logic       link_ok
);

    localparam int            TW       = $clog2(LINK_TO + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(LINK_TO);
    localparam logic [TW-1:0] TMR_ONE  = TW'(1);
    localparam logic [5:0]    PCNT_MIN = 6'(PRE_MIN);
    localparam logic [5:0]    PCNT_MAX = 6'd63;
    localparam logic [3:0]    NLPW_MIN = 4'(NLP_MIN);
    localparam logic [3:0]    NLPW_MAX = 4'(NLP_MAX);
    localparam logic [3:0]    NLPW_SAT = 4'd15;
    localparam logic [3:0]    NLP_NEED = 4'(LINK_PULSES);

    logic          w_level, w_rise, w_fall, w_bit, w_bit_vld, w_lost;
    eth_state_t    r_state, w_state_nxt;
    logic [5:0]    r_pcnt;
    logic          r_prev;
    logic [2:0]    r_bcnt;
    logic          r_got;
    logic          r_first;
    logic [7:0]    r_shift;
    logic          w_crc_bad;
    logic          r_nlp_arm;
    logic [3:0]    r_nlp_w;
    logic [3:0]    r_nlp_cnt;
    logic [3:0]    w_nlp_inc;
    logic [TW-1:0] r_link_tmr;
    logic          w_nlp_in_range, w_nlp_ok, w_nlp_bad, w_link_hold, w_expire;

    eth_manch_dec #(.SPB(SPB)) u_dec (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rx           (rx_in),
        .o_level        (w_level),
        .o_rise         (w_rise),
        .o_fall         (w_fall),
        .o_bit          (w_bit),
        .o_bit_vld      (w_bit_vld),
        .o_carrier_lost (w_lost)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_bit_vld) w_state_nxt = PRE;
            PRE: begin
                if (w_lost)
                    w_state_nxt = IDLE;
                else if (w_bit_vld && (w_bit == r_prev))
                    w_state_nxt = (w_bit && (r_pcnt >= PCNT_MIN)) ? DATA : DROP;
            end
            DATA, DROP: if (w_lost) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef ETH_RX_CRC_EN
    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (r_state == PRE && w_state_nxt == DATA)
            r_crc <= CRC32_INIT;
        else if (r_state == DATA && w_bit_vld)
            r_crc <= crc32_bit(r_crc, w_bit);
    end

    assign w_crc_bad = (r_crc != CRC32_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (r_state == DATA && w_bit_vld) r_shift <= {w_bit, r_shift[7:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            carrier  <= 1'b0;
            r_pcnt   <= 6'd0;
            r_prev   <= 1'b0;
            r_bcnt   <= 3'd0;
            r_got    <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_sof   <= 1'b0;
            rx_eof   <= 1'b0;
            rx_err   <= 1'b0;
            carrier  <= (w_state_nxt != IDLE);
            unique case (r_state)
                IDLE: if (w_bit_vld) begin
                    r_pcnt <= 6'd1;
                    r_prev <= w_bit;
                end
                PRE: if (w_bit_vld) begin
                    r_prev <= w_bit;
                    if (w_bit != r_prev && r_pcnt != PCNT_MAX) r_pcnt <= r_pcnt + 6'd1;
                    if (w_state_nxt == DATA) begin
                        r_bcnt  <= 3'd0;
                        r_got   <= 1'b0;
                        r_first <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_vld) begin
                        r_bcnt <= r_bcnt + 3'd1;
                        if (r_bcnt == 3'd7) begin
                            rx_valid <= 1'b1;
                            rx_data  <= {w_bit, r_shift[7:1]};
                            rx_sof   <= r_first;
                            r_first  <= 1'b0;
                            r_got    <= 1'b1;
                        end
                    end
                    // Loss trails the last mid-bit by several cycles, so eof never meets a strobe.
                    if (w_lost) begin
                        rx_eof <= 1'b1;
                        rx_err <= (r_bcnt != 3'd0) || !r_got || w_crc_bad;
                    end
                end
                default: ;
            endcase
        end
    end

    // A pulse is only measured if its rising edge arrives while the framer is idle.
    assign w_nlp_in_range = (r_nlp_w >= NLPW_MIN) && (r_nlp_w <= NLPW_MAX);
    assign w_nlp_ok       = w_fall && r_nlp_arm && w_nlp_in_range;
    assign w_nlp_bad      = w_fall && r_nlp_arm && !w_nlp_in_range;
    assign w_link_hold    = w_nlp_ok || carrier;
    assign w_expire       = !w_link_hold && (r_link_tmr == TMR_ONE);
    assign w_nlp_inc      = r_nlp_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nlp_arm  <= 1'b0;
            r_nlp_w    <= 4'd0;
            r_nlp_cnt  <= 4'd0;
            r_link_tmr <= '0;
            link_ok    <= 1'b0;
        end else begin
            if (w_rise && r_state == IDLE) begin
                r_nlp_arm <= 1'b1;
                r_nlp_w   <= 4'd1;
            end else if (w_fall) begin
                r_nlp_arm <= 1'b0;
            end else if (r_nlp_arm && w_level && r_nlp_w != NLPW_SAT) begin
                r_nlp_w <= r_nlp_w + 4'd1;
            end

            if (w_link_hold)            r_link_tmr <= TMR_LOAD;
            else if (r_link_tmr != '0)  r_link_tmr <= r_link_tmr - TMR_ONE;

            if (w_expire) begin
                r_nlp_cnt <= 4'd0;
                link_ok   <= 1'b0;
            end else if (w_nlp_bad) begin
                r_nlp_cnt <= 4'd0;
            end else if (w_nlp_ok) begin
                if (r_nlp_cnt < NLP_NEED) r_nlp_cnt <= w_nlp_inc;
                if (w_nlp_inc >= NLP_NEED) link_ok <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx.sv
// Directed bench for eth_rx: Manchester frames, framing errors, NLP link, mid-frame reset.
// Byte/eof expectations are queued as stimulus is sent and popped by the output monitor.
`timescale 1ns/1ps
module tb_eth_rx;

    localparam int LINK_TO_TB = 2000;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_sof, rx_eof, rx_err, carrier, link_ok;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   saw_carrier;
    logic [8:0] exp_q[$];
    logic       exp_eof_q[$];
    logic [7:0] pl[$];
    logic [7:0] empty_q[$];
    logic [31:0] crc;

    always #12.5 clk = ~clk;

    eth_rx #(
        .SPB(4), .PRE_MIN(16), .NLP_MIN(2), .NLP_MAX(8),
        .LINK_TO(LINK_TO_TB), .LINK_PULSES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_err(rx_err), .carrier(carrier), .link_ok(link_ok)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            logic [8:0] e;
            logic       ee;
            if (carrier) saw_carrier = 1'b1;
            if (!rx_eof) chk("err_outside_eof", 32'(rx_err), 32'd0);
            if (rx_valid) begin
                chk("byte_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rx_data", 32'(rx_data), 32'(e[7:0]));
                    chk("rx_sof", 32'(rx_sof), 32'(e[8]));
                end
            end
            if (rx_eof) begin
                chk("eof_pending", 32'(exp_eof_q.size() != 0), 32'd1);
                chk("eof_no_valid", 32'(rx_valid), 32'd0);
                if (exp_eof_q.size() != 0) begin
                    ee = exp_eof_q.pop_front();
                    chk("rx_err", 32'(rx_err), 32'(ee));
                end
            end
        end
    end

    // Bit 1 = low then high, bit 0 = high then low; 4 clk samples per bit.
    task automatic send_bit(input logic b);
        rx_in = ~b;
        repeat (2) @(negedge clk);
        rx_in = b;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] v, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) send_bit(v[k]);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) send_bit(i % 2 == 0);
    endtask

    // Line held high for 300 ns, then returned low so the next frame starts cleanly.
    task automatic trailer();
        rx_in = 1'b1;
        repeat (12) @(negedge clk);
        rx_in = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] bytes[$], input int nbits, input logic extra_err);
        send_pre(56);
        send_bits(8'hD5, 0, 7);
        for (int i = 0; i * 8 < nbits; i++) begin
            int nb;
            nb = (nbits - i * 8 >= 8) ? 8 : nbits - i * 8;
            send_bits(bytes[i], 0, nb - 1);
            if (nb == 8) exp_q.push_back({(i == 0), bytes[i]});
        end
        exp_eof_q.push_back((nbits % 8 != 0) || (nbits < 8) || extra_err);
        trailer();
        chk("frame_bytes_drained", 32'(exp_q.size()), 32'd0);
        chk("frame_eof_drained", 32'(exp_eof_q.size()), 32'd0);
    endtask

    task automatic nlp(input int w);
        rx_in = 1'b1;
        repeat (w) @(negedge clk);
        rx_in = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_rx_sof", 32'(rx_sof), 32'd0);
        chk("reset_rx_eof", 32'(rx_eof), 32'd0);
        chk("reset_rx_err", 32'(rx_err), 32'd0);
        chk("reset_carrier", 32'(carrier), 32'd0);
        chk("reset_link_ok", 32'(link_ok), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Link pulses: spacing and timeout scaled down with LINK_TO_TB.
        nlp(4);
        repeat (320) @(negedge clk);
        chk("link_after_1st", 32'(link_ok), 32'd0);
        nlp(4);
        repeat (20) @(negedge clk);
        chk("link_after_2nd", 32'(link_ok), 32'd1);
        repeat (300) @(negedge clk);
        nlp(4);
        repeat (1900) @(negedge clk);
        chk("link_hold_before_to", 32'(link_ok), 32'd1);
        repeat (200) @(negedge clk);
        chk("link_dropped_after_to", 32'(link_ok), 32'd0);
        nlp(4);
        repeat (320) @(negedge clk);
        nlp(20);
        repeat (320) @(negedge clk);
        nlp(4);
        repeat (20) @(negedge clk);
        chk("link_wide_pulse_resets", 32'(link_ok), 32'd0);
        repeat (40) @(negedge clk);

        pl = '{8'h55, 8'h01, 8'hA5};
        frame(pl, 24, 1'b0);
        frame(pl, 19, 1'b0);
        frame(empty_q, 0, 1'b0);

        // Alternation run is only 11 bits long when the "11" terminator arrives.
        saw_carrier = 1'b0;
        send_pre(10);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bits(8'h55, 0, 7);
        trailer();
        chk("short_pre_carrier_seen", 32'(saw_carrier), 32'd1);
        chk("short_pre_carrier_low", 32'(carrier), 32'd0);

        send_pre(56);
        send_bits(8'hD5, 0, 7);
        send_bits(8'h55, 0, 7);
        exp_q.push_back({1'b1, 8'h55});
        send_bits(8'h01, 0, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rx_data", 32'(rx_data), 32'd0);
        chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
        chk("midrst_rx_eof", 32'(rx_eof), 32'd0);
        chk("midrst_rx_err", 32'(rx_err), 32'd0);
        chk("midrst_carrier", 32'(carrier), 32'd0);
        chk("midrst_link_ok", 32'(link_ok), 32'd0);
        rst_n = 1'b1;
        send_bits(8'h01, 4, 7);
        send_bits(8'hA5, 0, 7);
        trailer();
        pl = '{8'hFF, 8'h00, 8'h3C};
        frame(pl, 24, 1'b0);

`ifdef ETH_RX_CRC_EN
        pl = {};
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            b = 8'(i * 7 + 3);
            pl.push_back(b);
            for (int k = 0; k < 8; k++)
                crc = (crc >> 1) ^ ((crc[0] ^ b[k]) ? 32'hEDB88320 : 32'h0);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) pl.push_back(crc[8 * k +: 8]);
        frame(pl, 512, 1'b0);
        pl[10] = pl[10] ^ 8'h04;
        frame(pl, 512, 1'b1);
`endif

        repeat (50) @(negedge clk);
        chk("final_bytes_left", 32'(exp_q.size()), 32'd0);
        chk("final_eofs_left", 32'(exp_eof_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
